// File: rtl/lfsr_128bit_sync_checker.sv
// Self-synchronising receive checker for the x^128+x^126+x^101+x^99+1 keystream.
// Define LFSR_SYNC_BITCNT_EN to add o_bit_cnt, a saturating count of bits compared while locked.
module lfsr_128bit_sync_checker #(
  parameter int LOCK_CNT    = 64,
  parameter int WIN_LEN     = 256,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_resync,
  input  logic             i_clear_cnt,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
`ifdef LFSR_SYNC_BITCNT_EN
  ,
  output logic [31:0]      o_bit_cnt
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int LW = $clog2(LOSS_THRESH + 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THRESH - 1);

  logic [1:0]       state, state_n;
  logic [127:0]     hist;
  logic [6:0]       fill_cnt, fill_cnt_n;
  logic [MW-1:0]    match_cnt, match_cnt_n;
  logic [WW-1:0]    win_cnt, win_cnt_n;
  logic [LW-1:0]    miss_cnt, miss_cnt_n;
  logic             locked_n;
  logic             err_n;
  logic [CNT_W-1:0] err_cnt_n;

  logic vld_p0;
  logic pred_p0;
  logic miss_p0;
  logic hist_zero_p0;

  function automatic logic [CNT_W-1:0] sat_inc_err(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: prediction from the recurrence and compare against the incoming bit
  assign vld_p0       = i_valid && !i_resync;
  assign pred_p0      = hist[127] ^ hist[125] ^ hist[100] ^ hist[98];
  assign miss_p0      = vld_p0 && (i_bit != pred_p0);
  assign hist_zero_p0 = (hist == '0);

  always_comb begin
    state_n     = state;
    fill_cnt_n  = fill_cnt;
    match_cnt_n = match_cnt;
    win_cnt_n   = win_cnt;
    miss_cnt_n  = miss_cnt;
    locked_n    = o_locked;
    err_n       = 1'b0;
    err_cnt_n   = o_err_cnt;

    if (i_resync) begin
      state_n     = ST_HUNT;
      fill_cnt_n  = '0;
      match_cnt_n = '0;
      win_cnt_n   = '0;
      miss_cnt_n  = '0;
      locked_n    = 1'b0;
    end else if (i_valid) begin
      case (state)
        ST_HUNT: begin
          if (fill_cnt == 7'd127) begin
            state_n     = ST_VERIFY;
            fill_cnt_n  = '0;
            match_cnt_n = '0;
          end else begin
            fill_cnt_n = fill_cnt + 7'd1;
          end
        end
        ST_VERIFY: begin
          // an all-zero history predicts zeros forever, so it never earns credit
          if (!miss_p0 && !hist_zero_p0) begin
            if (match_cnt == MATCH_LAST) begin
              state_n     = ST_LOCKED;
              locked_n    = 1'b1;
              match_cnt_n = '0;
              win_cnt_n   = '0;
              miss_cnt_n  = '0;
            end else begin
              match_cnt_n = match_cnt + MW'(1);
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        ST_LOCKED: begin
          if (miss_p0) begin
            err_n     = 1'b1;
            err_cnt_n = sat_inc_err(o_err_cnt);
          end
          // loss takes priority over the window rollover on the same bit
          if (miss_p0 && miss_cnt == MISS_LAST) begin
            state_n    = ST_HUNT;
            locked_n   = 1'b0;
            fill_cnt_n = '0;
            win_cnt_n  = '0;
            miss_cnt_n = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt_n  = '0;
            miss_cnt_n = '0;
          end else begin
            win_cnt_n = win_cnt + WW'(1);
            if (miss_p0) miss_cnt_n = miss_cnt + LW'(1);
          end
        end
        default: begin
          state_n  = ST_HUNT;
          locked_n = 1'b0;
        end
      endcase
    end

    if (i_clear_cnt) err_cnt_n = '0;
  end

  // Stage p1: registered state, history and outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_HUNT;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      miss_cnt  <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state     <= state_n;
      fill_cnt  <= fill_cnt_n;
      match_cnt <= match_cnt_n;
      win_cnt   <= win_cnt_n;
      miss_cnt  <= miss_cnt_n;
      o_locked  <= locked_n;
      o_err     <= err_n;
      o_err_cnt <= err_cnt_n;
      if (vld_p0) hist <= {hist[126:0], i_bit};
    end
  end

`ifdef LFSR_SYNC_BITCNT_EN
  function automatic logic [31:0] sat_inc_bits(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bit_cnt <= '0;
    end else if (i_clear_cnt) begin
      o_bit_cnt <= '0;
    end else if (vld_p0 && state == ST_LOCKED) begin
      o_bit_cnt <= sat_inc_bits(o_bit_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_128bit_sync_checker.sv
// Self-checking bench for lfsr_128bit_sync_checker against a queue-based keystream/link model.
module tb_lfsr_128bit_sync_checker;

  localparam int LOCK_CNT    = 64;
  localparam int WIN_LEN     = 256;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_W       = 4;
  localparam int ERR_MAX     = (1 << CNT_W) - 1;
  localparam int LOCK_BIT    = 128 + LOCK_CNT;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_bit = 1'b0;
  logic             i_resync = 1'b0;
  logic             i_clear_cnt = 1'b0;
  logic             o_locked;
  logic             o_err;
  logic [CNT_W-1:0] o_err_cnt;
`ifdef LFSR_SYNC_BITCNT_EN
  logic [31:0]      o_bit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  lfsr_128bit_sync_checker #(
    .LOCK_CNT(LOCK_CNT),
    .WIN_LEN(WIN_LEN),
    .LOSS_THRESH(LOSS_THRESH),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_bit(i_bit),
    .i_resync(i_resync),
    .i_clear_cnt(i_clear_cnt),
    .o_locked(o_locked),
    .o_err(o_err),
    .o_err_cnt(o_err_cnt)
`ifdef LFSR_SYNC_BITCNT_EN
    ,
    .o_bit_cnt(o_bit_cnt)
`endif
  );

  // Keystream generator: seed bits first, then k[n] = k[n-128]^k[n-126]^k[n-101]^k[n-99]
  bit ks[$];
  int gpos;

  task automatic gen_seed(input logic [127:0] seed);
    ks.delete();
    gpos = 0;
    for (int i = 0; i < 128; i++) ks.push_back(seed[i]);
  endtask

  task automatic gen_bit(output bit b);
    while (ks.size() <= gpos) begin
      int n;
      n = ks.size();
      ks.push_back(ks[n-128] ^ ks[n-126] ^ ks[n-101] ^ ks[n-99]);
    end
    b = ks[gpos];
    gpos++;
  endtask

  // Link model: rxq holds the last 128 received bits, oldest first
  bit     rxq[$];
  int     m_mode;
  int     m_fill, m_match, m_win, m_miss, m_errcnt;
  bit     m_err, m_locked;
  longint m_bitcnt;

  task automatic model_reset();
    rxq.delete();
    for (int i = 0; i < 128; i++) rxq.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_miss = 0;
    m_errcnt = 0; m_err = 1'b0; m_locked = 1'b0; m_bitcnt = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit rs, input bit clr);
    bit p, nz;
    m_err = 1'b0;
    if (rs) begin
      m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_miss = 0; m_locked = 1'b0;
    end else if (v) begin
      p = rxq[0] ^ rxq[2] ^ rxq[27] ^ rxq[29];
      nz = 1'b0;
      foreach (rxq[i]) if (rxq[i]) nz = 1'b1;
      case (m_mode)
        0: begin
          m_fill++;
          if (m_fill == 128) begin m_mode = 1; m_fill = 0; m_match = 0; end
        end
        1: begin
          if (b == p && nz) m_match++;
          else m_match = 0;
          if (m_match == LOCK_CNT) begin
            m_mode = 2; m_locked = 1'b1; m_win = 0; m_miss = 0;
          end
        end
        default: begin
          if (m_bitcnt < 64'hFFFF_FFFF) m_bitcnt++;
          m_win++;
          if (b != p) begin
            m_err = 1'b1;
            if (m_errcnt < ERR_MAX) m_errcnt++;
            m_miss++;
          end
          if (m_miss == LOSS_THRESH) begin
            m_mode = 0; m_locked = 1'b0; m_fill = 0; m_win = 0; m_miss = 0;
          end else if (m_win == WIN_LEN) begin
            m_win = 0; m_miss = 0;
          end
        end
      endcase
      rxq.push_back(b);
      void'(rxq.pop_front());
    end
    if (clr) begin m_errcnt = 0; m_bitcnt = 0; end
  endtask

  task automatic drive(input bit v, input bit b, input bit rs, input bit clr);
    i_valid = v; i_bit = b; i_resync = rs; i_clear_cnt = clr;
    @(posedge i_clk);
    #1;
    model_step(v, b, rs, clr);
    i_valid = 1'b0; i_resync = 1'b0; i_clear_cnt = 1'b0; i_bit = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_resync = 1'b0; i_clear_cnt = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic lock_up(input int gap);
    bit b;
    for (int i = 0; i < LOCK_BIT; i++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
      idle(gap);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_locked !== 1'b0 || o_err !== 1'b0 || o_err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: locked=%b err=%b cnt=%0d, required 0 0 0", o_locked, o_err, o_err_cnt);
    end
  endtask

  task automatic test_lock();
    bit b;
    do_reset();
    gen_seed(128'h1);
    for (int i = 1; i <= LOCK_BIT; i++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
      checks++;
      if (o_locked !== (i >= LOCK_BIT) || o_err !== 1'b0 || o_err_cnt !== m_errcnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL lock_acquire bit %0d: locked=%b err=%b cnt=%0d, required %b 0 %0d",
                 i, o_locked, o_err, o_err_cnt, (i >= LOCK_BIT), m_errcnt);
      end
      idle(7);
      checks++;
      if (o_locked !== (i >= LOCK_BIT) || o_err !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold bit %0d: locked=%b err=%b", i, o_locked, o_err);
      end
    end
    checks++;
    if (o_err_cnt !== '0) begin
      errors++;
      $display("FAIL lock_errcnt: cnt=%0d, required 0", o_err_cnt);
    end
`ifdef LFSR_SYNC_BITCNT_EN
    checks++;
    if (o_bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL lock_bitcnt: bit_cnt=%0d, required 0", o_bit_cnt);
    end
`endif
  endtask

  task automatic test_single_error();
    bit b;
    int nclean, pulses, fed, gap;
    nclean = $urandom_range(5, 40);
    pulses = 0;
    fed = 0;
    for (int i = 0; i < nclean + 1 + 140; i++) begin
      gen_bit(b);
      if (i == nclean) b = ~b;
      drive(1'b1, b, 1'b0, 1'b0);
      fed++;
      if (o_err === 1'b1) pulses++;
      checks++;
      if (o_locked !== m_locked || o_err !== m_err || o_err_cnt !== m_errcnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL single_err bit %0d: locked=%b err=%b cnt=%0d, required %b %b %0d",
                 i, o_locked, o_err, o_err_cnt, m_locked, m_err, m_errcnt);
      end
      gap = $urandom_range(0, 3);
      idle(gap);
      if (gap > 0) begin
        checks++;
        if (o_err !== 1'b0) begin
          errors++;
          $display("FAIL err_pulse_width bit %0d: err=%b after idle, required 0", i, o_err);
        end
      end
    end
    checks++;
    if (pulses != 5 || o_err_cnt !== 4'd5 || o_locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err_total: pulses=%0d cnt=%0d locked=%b, required 5 5 1", pulses, o_err_cnt, o_locked);
    end
`ifdef LFSR_SYNC_BITCNT_EN
    checks++;
    if (o_bit_cnt !== 32'(fed)) begin
      errors++;
      $display("FAIL single_err_bitcnt: bit_cnt=%0d, required %0d", o_bit_cnt, fed);
    end
`endif
  endtask

  task automatic test_burst();
    bit b;
    int relock_at;
    do_reset();
    gen_seed({$urandom, $urandom, $urandom, $urandom} | 128'h1);
    lock_up(0);
    checks++;
    if (o_locked !== 1'b1) begin
      errors++;
      $display("FAIL burst_prelock: locked=%b, required 1", o_locked);
    end
    repeat ($urandom_range(0, 30)) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 16; k++) begin
      gen_bit(b);
      drive(1'b1, ~b, 1'b0, 1'b0);
      checks++;
      if (o_locked !== (k < LOSS_THRESH) || o_locked !== m_locked || o_err_cnt !== m_errcnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL burst bit %0d: locked=%b cnt=%0d, required %b %0d", k, o_locked, o_err_cnt, (k < LOSS_THRESH), m_errcnt);
      end
    end
    checks++;
    if (o_err_cnt !== 4'd8) begin
      errors++;
      $display("FAIL burst_errcnt: cnt=%0d, required 8", o_err_cnt);
    end
    relock_at = 0;
    for (int i = 1; i <= 400 && relock_at == 0; i++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
      checks++;
      if (o_locked !== m_locked || o_err !== m_err) begin
        errors++;
        $display("FAIL burst_relock bit %0d: locked=%b err=%b, required %b %b", i, o_locked, o_err, m_locked, m_err);
      end
      if (o_locked === 1'b1) relock_at = i;
    end
    checks++;
    if (relock_at != LOCK_BIT) begin
      errors++;
      $display("FAIL burst_relock_time: relocked after %0d clean bits, required %0d", relock_at, LOCK_BIT);
    end
  endtask

  task automatic test_zero_stream();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_locked !== 1'b0 || o_err !== 1'b0) begin
        errors++;
        $display("FAIL zero_stream bit %0d: locked=%b err=%b, required 0 0", i, o_locked, o_err);
      end
      idle($urandom_range(0, 1));
    end
  endtask

  task automatic test_clear_collision();
    bit b;
    do_reset();
    gen_seed({$urandom, $urandom, $urandom, $urandom} | 128'h1);
    lock_up(0);
    repeat (10) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
    end
    gen_bit(b);
    drive(1'b1, ~b, 1'b0, 1'b0);
    checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 4'd1) begin
      errors++;
      $display("FAIL clear_setup: err=%b cnt=%0d, required 1 1", o_err, o_err_cnt);
    end
    repeat (98) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
    end
    gen_bit(b);
    drive(1'b1, b, 1'b0, 1'b1);
    checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 4'd0 || o_err !== m_err || o_locked !== 1'b1) begin
      errors++;
      $display("FAIL clear_collision: err=%b cnt=%0d locked=%b, required 1 0 1", o_err, o_err_cnt, o_locked);
    end
`ifdef LFSR_SYNC_BITCNT_EN
    checks++;
    if (o_bit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL clear_bitcnt: bit_cnt=%0d, required 0", o_bit_cnt);
    end
`endif
  endtask

  task automatic test_resync_and_reset();
    bit b;
    do_reset();
    gen_seed(128'h1);
    lock_up(1);
    gen_bit(b);
    drive(1'b1, ~b, 1'b0, 1'b0);
    repeat (5) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
    end
    drive(1'b1, 1'($urandom), 1'b1, 1'b0);
    checks++;
    if (o_locked !== 1'b0 || o_err !== 1'b0 || o_err_cnt !== 4'd1) begin
      errors++;
      $display("FAIL resync: locked=%b err=%b cnt=%0d, required 0 0 1", o_locked, o_err, o_err_cnt);
    end
    for (int i = 1; i <= LOCK_BIT; i++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
      checks++;
      if (o_locked !== (i >= LOCK_BIT) || o_err_cnt !== 4'd1) begin
        errors++;
        $display("FAIL resync_relock bit %0d: locked=%b cnt=%0d, required %b 1", i, o_locked, o_err_cnt, (i >= LOCK_BIT));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (150) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_locked !== 1'b0 || o_err !== 1'b0 || o_err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: locked=%b err=%b cnt=%0d, required 0 0 0", o_locked, o_err, o_err_cnt);
    end
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= LOCK_BIT; i++) begin
      gen_bit(b);
      drive(1'b1, b, 1'b0, 1'b0);
      checks++;
      if (o_locked !== (i >= LOCK_BIT)) begin
        errors++;
        $display("FAIL post_reset_lock bit %0d: locked=%b, required %b", i, o_locked, (i >= LOCK_BIT));
      end
    end
  endtask

  task automatic test_random();
    bit b;
    bit rs, clr;
    int locks;
    do_reset();
    gen_seed({$urandom, $urandom, $urandom, $urandom} | 128'h1);
    locks = 0;
    for (int i = 0; i < 3000; i++) begin
      gen_bit(b);
      if ($urandom_range(0, 399) == 0) b = ~b;
      rs  = ($urandom_range(0, 1499) == 0);
      clr = ($urandom_range(0, 499) == 0);
      if (rs) gpos--;
      drive(1'b1, b, rs, clr);
      if (o_locked === 1'b1 && m_mode == 2 && m_win == 0 && m_miss == 0) locks++;
      checks++;
      if (o_locked !== m_locked || o_err !== m_err || o_err_cnt !== m_errcnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL random bit %0d: locked=%b err=%b cnt=%0d, required %b %b %0d",
                 i, o_locked, o_err, o_err_cnt, m_locked, m_err, m_errcnt);
      end
`ifdef LFSR_SYNC_BITCNT_EN
      checks++;
      if (o_bit_cnt !== m_bitcnt[31:0]) begin
        errors++;
        $display("FAIL random_bitcnt bit %0d: bit_cnt=%0d, required %0d", i, o_bit_cnt, m_bitcnt);
      end
`endif
      idle($urandom_range(0, 2));
    end
    checks++;
    if (locks == 0) begin
      errors++;
      $display("FAIL random_never_locked: locks=%0d, required >0", locks);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_burst();
    test_zero_stream();
    test_clear_collision();
    test_resync_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
